// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings and default sizing for the round-robin channel mux.
package mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   DEF_N      = 3;
  localparam int   DEF_CH     = 8;
endpackage

// File: rtl/mux_nx1_rr_arbiter.sv
// rr_arbiter: rotating-priority search starting just above ptr, wrapping at CH.
module rr_arbiter #(
  parameter int CH = 8,
  parameter int SW = $clog2(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic [SW-1:0] gnt,
  output logic          gnt_valid
);
  always_comb begin
    gnt = '0;
    gnt_valid = 1'b0;
    // Walk from the farthest candidate back to ptr+1 so the nearest requester wins last.
    for (int k = CH; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % CH;
      if (en && req[idx]) begin
        gnt = SW'(idx);
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: CH-to-1 registered mux with fixed-select or round-robin grant and
// valid/ready handshaking on every channel and the output.
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CH = DEF_CH,
  parameter int SW = $clog2(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH*N-1:0] w,
  input  logic [CH-1:0] w_valid,
  output logic [CH-1:0] w_ready,
  input  logic [SW-1:0] s,
  input  logic          mode,
  output logic [N-1:0]  f,
  output logic          f_valid,
  input  logic          f_ready,
  output logic [SW-1:0] f_sel
);
  logic [N-1:0]  w_arr [CH];
  logic [SW-1:0] ptr, arb_gnt, g;
  logic          arb_valid, fix_ok, gv, load, xfer;
  genvar i;
  for (i = 0; i < CH; i++) begin : g_ch
    assign w_arr[i] = w[i*N +: N];
  end
  rr_arbiter #(.CH(CH), .SW(SW)) u_arb (
    .req(w_valid), .ptr(ptr), .en(mode == MODE_RR), .gnt(arb_gnt), .gnt_valid(arb_valid)
  );
  // rst_n gating keeps every channel un-accepted while reset is held.
  assign load    = rst_n && (!f_valid || f_ready);
  assign fix_ok  = (int'(s) < CH) && w_valid[s];
  assign g       = (mode == MODE_RR) ? arb_gnt : s;
  assign gv      = (mode == MODE_RR) ? arb_valid : fix_ok;
  assign xfer    = gv && load;
  assign w_ready = xfer ? (CH'(1'b1) << g) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f       <= '0;
      f_sel   <= '0;
      f_valid <= 1'b0;
      ptr     <= SW'(CH-1);
    end else begin
      if (xfer) begin
        f     <= w_arr[g];
        f_sel <= g;
        if (mode == MODE_RR) ptr <= g;
      end
      if (load) f_valid <= xfer;
    end
  end
endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb_mux_nx1_rr: directed and random steps against a grant model and an output scoreboard.
module tb_mux_nx1_rr;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] w = '0;
  logic [7:0]  w_valid = '0;
  logic [7:0]  w_ready;
  logic [2:0]  s = '0;
  logic        mode = 1'b0;
  logic [2:0]  f;
  logic        f_valid;
  logic        f_ready = 1'b0;
  logic [2:0]  f_sel;
  int checks = 0;
  int errors = 0;
  int mdl_ptr = 7;
  logic mdl_fv = 1'b0;
  logic [5:0] sb [$];

  mux_nx1_rr #(.N(3), .CH(8)) dut (
    .clk(clk), .rst_n(rst_n), .w(w), .w_valid(w_valid), .w_ready(w_ready),
    .s(s), .mode(mode), .f(f), .f_valid(f_valid), .f_ready(f_ready), .f_sel(f_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_w(input logic [2:0] base);
    for (int i = 0; i < 8; i++) w[i*3 +: 3] = 3'(base + 3'(i*3));
  endtask

  function automatic void grant(input logic md, input logic [2:0] sv, input logic [7:0] wv,
                                output logic gv, output logic [2:0] g);
    gv = 1'b0;
    g = '0;
    if (!md) begin
      gv = wv[sv];
      g = sv;
    end else begin
      for (int k = 1; k <= 8; k++)
        if (!gv && wv[(mdl_ptr + k) % 8]) begin
          gv = 1'b1;
          g = 3'((mdl_ptr + k) % 8);
        end
    end
  endfunction

  task automatic step(input logic md, input logic [2:0] sv, input logic [7:0] wv, input logic fr);
    logic gv, ld;
    logic [2:0] g;
    logic [5:0] exp_out;
    mode = md; s = sv; w_valid = wv; f_ready = fr;
    #1;
    chk("f_valid", 32'(f_valid), 32'(mdl_fv));
    if (mdl_fv) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $error("FAIL scoreboard_empty: observed f=%0h sel=%0d expected a queued word", f, f_sel);
      end else begin
        exp_out = fr ? sb.pop_front() : sb[0];
        chk(fr ? "out_word" : "held_word", 32'({f_sel, f}), 32'(exp_out));
      end
    end
    grant(md, sv, wv, gv, g);
    ld = !mdl_fv || fr;
    chk("w_ready", 32'(w_ready), (gv && ld) ? (32'd1 << g) : 32'd0);
    if (gv && ld) begin
      sb.push_back({g, w[g*3 +: 3]});
      if (md) mdl_ptr = int'(g);
    end
    if (ld) mdl_fv = gv && ld;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    mdl_ptr = 7;
    mdl_fv = 1'b0;
    sb.delete();
  endtask

  initial begin
    mode = 1'b1; w_valid = 8'hFF; set_w(3'd1);
    #3;
    chk("rst_f_valid", 32'(f_valid), 0);
    chk("rst_f", 32'(f), 0);
    chk("rst_f_sel", 32'(f_sel), 0);
    chk("rst_w_ready", 32'(w_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Round-robin over all channels from reset: 0..7 then wrap to 0.
    for (int i = 0; i < 9; i++) step(1'b1, 3'd0, 8'hFF, 1'b1);
    chk("rr_ptr_after_wrap", 32'(dut.ptr), 0);
    // Fixed select of channel 5 carrying 3'b101.
    w[15 +: 3] = 3'b101;
    step(1'b0, 3'd5, 8'h20, 1'b1);
    step(1'b0, 3'd5, 8'h00, 1'b1);
    chk("fixed_keeps_ptr", 32'(dut.ptr), 0);
    // Two requesters at the ends alternate 7,0,7.
    set_w(3'd4);
    for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 8'h81, 1'b1);
    // Backpressure for four cycles, then a simultaneous drain and load.
    set_w(3'd6);
    for (int i = 0; i < 4; i++) step(1'b1, 3'd0, 8'hFF, 1'b0);
    step(1'b1, 3'd0, 8'hFF, 1'b1);
    chk("throughput_valid_kept", 32'(f_valid), 1);
    // Fixed select of an idle channel: no grant, pending word drains.
    step(1'b0, 3'd2, 8'hFB, 1'b1);
    step(1'b0, 3'd2, 8'hFB, 1'b1);
    chk("drained", 32'(f_valid), 0);
    // Asynchronous reset between clock edges mid-stream.
    for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 8'hFF, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_f_valid", 32'(f_valid), 0);
    chk("async_rst_w_ready", 32'(w_ready), 0);
    chk("async_rst_f_sel", 32'(f_sel), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'd0, 8'h6C, 1'b1);
    step(1'b1, 3'd0, 8'h6C, 1'b1);
    // Random traffic across both modes.
    for (int i = 0; i < 200; i++) begin
      w = 24'($urandom);
      step(1'($urandom), 3'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
